pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Combines four stall/flush sources into per-stage load and flush controls:
  - the load-use hazard flag from the hazard detection unit;
  - an I-cache miss;
  - a D-cache miss;
  - a taken branch/jump resolved in EX.
- Holds a pending redirect when a branch resolves while a fetch is still outstanding.
- Keeps saturating performance counters.

Parameters:
- CNT_WIDTH, 32, width of each saturating performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_read  in  1  IF stage fetch request to I-cache
- imem_resp  in  1  I-cache response; stays high while imem_read and address are held
- dmem_access  in  1  MEM stage read or write request to D-cache
- dmem_resp  in  1  D-cache response
- load_use_hazard  in  1  stall request from the hazard detection unit
- branch_taken_EX  in  1  EX stage control transfer is taken
- branch_target  in  32  EX stage target address
- load_pc  out  1  PC register enable
- pc_redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  32  redirect address
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register enables
- flush_if_id, flush_id_ex  out  1 each  load a NOP in place of incoming contents (valid only with the matching load)
- bubble_id_ex  out  1  control-word mux selects the NOP control word for ID/EX
- stall_cycles  out  CNT_WIDTH  cycles with load_pc=0
- branch_count  out  CNT_WIDTH  accepted taken branches

Behaviour:
- Definitions: ms = dmem_access & ~dmem_resp; fs = imem_read & ~imem_resp.
- State register: RUN or SQUASH. pending_target is a 32-bit register.
- Control outputs are combinational from state and inputs. State, pending_target and counters update on posedge clk.
- Any output not named in a rule below is 0.
- Reset:
  - state=RUN, pending_target=0, counters=0.
  - While rst=1, all control outputs are 0.
  - Reset in SQUASH discards the pending redirect.
- Priority, evaluated each cycle (first match wins):
  1. ms (global freeze):
     - All load_* = 0; no flush or bubble.
     - branch_taken_EX is ignored; EX holds and re-presents it.
     - State and pending_target hold.
  2. Otherwise load_ex_mem = load_mem_wb = 1, and the first matching case applies:
     - a. branch_taken_EX, fs=1:
       - load_if_id=1, flush_if_id=1, load_id_ex=1, flush_id_ex=1, load_pc=0.
       - pending_target <= branch_target; state <= SQUASH.
     - b. branch_taken_EX, fs=0:
       - load_pc=1, pc_redirect=1, redirect_pc=branch_target.
       - load_if_id=1, flush_if_id=1, load_id_ex=1, flush_id_ex=1.
       - A simultaneous load_use_hazard is overridden: bubble_id_ex=0.
     - c. SQUASH with fs=1:
       - load_pc=0, load_if_id=1, flush_if_id=1, load_id_ex=1.
       - load_use_hazard is ignored.
     - d. SQUASH with fs=0 (wrong-path fetch returned):
       - load_pc=1, pc_redirect=1, redirect_pc=pending_target.
       - load_if_id=1, flush_if_id=1, load_id_ex=1.
       - state <= RUN.
     - e. load_use_hazard:
       - load_pc=0, load_if_id=0, load_id_ex=1, bubble_id_ex=1.
     - f. fs:
       - load_pc=0, load_if_id=1, flush_if_id=1, load_id_ex=1.
     - g. Otherwise: all load_* = 1.
- Whenever pc_redirect=0, redirect_pc=pending_target.
- A branch in SQUASH state is legal: case a/b takes priority. Under fs it overwrites pending_target.
- Counters:
  - stall_cycles increments on any non-reset cycle with load_pc=0.
  - branch_count increments on each cycle matching case a or b.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
- Latency: a redirect takes effect in the same cycle as the decision (PC loads at the next edge).
- A redirect is never issued while fs=1 or ms=1.

Test Plan:
1. Load-use: one cycle of load_use_hazard=1, no misses -> load_pc=0, load_if_id=0, load_id_ex=1, bubble_id_ex=1, load_ex_mem=1; stall_cycles 0->1.
2. D-miss:
   - Stimulus: dmem_access=1, dmem_resp=0 for 5 cycles, with branch_taken_EX=1 and branch_target=0x00000060 throughout.
   - During the miss: all load_*=0 for 5 cycles; pc_redirect=0.
   - Cycle 6, dmem_resp=1: pc_redirect=1, redirect_pc=0x60, both flushes=1; branch_count=1.
3. Branch during I-miss:
   - Stimulus: imem_read=1, imem_resp=0; branch_taken_EX=1 with target 0x00000400; branch then retires.
   - Branch cycle: load_pc=0, state SQUASH.
   - Next 2 cycles: flush_if_id=1.
   - imem_resp=1 on the 3rd cycle: pc_redirect=1, redirect_pc=0x400, flush_if_id=1, state RUN.
4. Simultaneous branch_taken_EX=1 and load_use_hazard=1 -> load_pc=1, flush_if_id=1, flush_id_ex=1, bubble_id_ex=0.
5. Reset in SQUASH: assert rst for 1 cycle -> all controls 0, counters 0; after release with no misses, load_pc=1, pc_redirect=0.
6. Saturation: CNT_WIDTH=4, 20 consecutive load-use cycles -> stall_cycles=15, holds at 15.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// Pipeline stall/flush control bundle: fetch/memory handshakes and hazard
// requests in, per-stage register enables and PC redirect out.
interface pipeline_stall_controller_if;
  // Requests from the pipeline
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_access;
  logic        dmem_resp;
  logic        load_use_hazard;
  logic        branch_taken_EX;
  logic [31:0] branch_target;
  // Controls back to the pipeline
  logic        load_pc;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        load_if_id;
  logic        load_id_ex;
  logic        load_ex_mem;
  logic        load_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        bubble_id_ex;

  // Pipeline datapath side
  modport master (
    output imem_read, imem_resp, dmem_access, dmem_resp, load_use_hazard,
           branch_taken_EX, branch_target,
    input  load_pc, pc_redirect, redirect_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, flush_if_id, flush_id_ex, bubble_id_ex
  );

  // Stall controller side
  modport slave (
    input  imem_read, imem_resp, dmem_access, dmem_resp, load_use_hazard,
           branch_taken_EX, branch_target,
    output load_pc, pc_redirect, redirect_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, flush_if_id, flush_id_ex, bubble_id_ex
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for a 5-stage pipeline. Merges D-miss freeze,
// taken branches, I-miss stalls and load-use bubbles into per-stage controls,
// remembers a redirect that arrived while a fetch was still outstanding, and
// keeps saturating stall/branch counters.
module pipeline_stall_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_stall_controller_if.slave bus_io,
  output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [CNT_WIDTH-1:0]     branch_count
);

  typedef enum logic [0:0] {StRun, StSquash} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pending_target_q, pending_target_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, branch_cnt_q;
  logic                   mem_stall, fetch_stall;
  logic                   branch_accept;

  assign mem_stall   = bus_io.dmem_access & ~bus_io.dmem_resp;
  assign fetch_stall = bus_io.imem_read & ~bus_io.imem_resp;

  // Priority decode of stall/flush sources into stage controls and next state
  always_comb begin
    bus_io.load_pc      = 1'b0;
    bus_io.pc_redirect  = 1'b0;
    bus_io.redirect_pc  = pending_target_q;
    bus_io.load_if_id   = 1'b0;
    bus_io.load_id_ex   = 1'b0;
    bus_io.load_ex_mem  = 1'b0;
    bus_io.load_mem_wb  = 1'b0;
    bus_io.flush_if_id  = 1'b0;
    bus_io.flush_id_ex  = 1'b0;
    bus_io.bubble_id_ex = 1'b0;
    state_d             = state_q;
    pending_target_d    = pending_target_q;
    branch_accept       = 1'b0;

    if (rst) begin
      // All controls stay low; registers are cleared at the edge
    end else if (mem_stall) begin
      // Global freeze: EX re-presents any branch once the miss clears
    end else begin
      bus_io.load_ex_mem = 1'b1;
      bus_io.load_mem_wb = 1'b1;
      if (bus_io.branch_taken_EX && fetch_stall) begin
        // Cannot redirect mid-fetch: squash younger work and park the target
        bus_io.load_if_id  = 1'b1;
        bus_io.flush_if_id = 1'b1;
        bus_io.load_id_ex  = 1'b1;
        bus_io.flush_id_ex = 1'b1;
        pending_target_d   = bus_io.branch_target;
        state_d            = StSquash;
        branch_accept      = 1'b1;
      end else if (bus_io.branch_taken_EX) begin
        bus_io.load_pc     = 1'b1;
        bus_io.pc_redirect = 1'b1;
        bus_io.redirect_pc = bus_io.branch_target;
        bus_io.load_if_id  = 1'b1;
        bus_io.flush_if_id = 1'b1;
        bus_io.load_id_ex  = 1'b1;
        bus_io.flush_id_ex = 1'b1;
        branch_accept      = 1'b1;
      end else if (state_q == StSquash) begin
        bus_io.load_if_id  = 1'b1;
        bus_io.flush_if_id = 1'b1;
        bus_io.load_id_ex  = 1'b1;
        if (!fetch_stall) begin
          // Wrong-path fetch has returned; now safe to redirect
          bus_io.load_pc     = 1'b1;
          bus_io.pc_redirect = 1'b1;
          state_d            = StRun;
        end
      end else if (bus_io.load_use_hazard) begin
        bus_io.load_id_ex   = 1'b1;
        bus_io.bubble_id_ex = 1'b1;
      end else if (fetch_stall) begin
        bus_io.load_if_id  = 1'b1;
        bus_io.flush_if_id = 1'b1;
        bus_io.load_id_ex  = 1'b1;
      end else begin
        bus_io.load_pc    = 1'b1;
        bus_io.load_if_id = 1'b1;
        bus_io.load_id_ex = 1'b1;
      end
    end
  end

  // Sequencer state and parked redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StRun;
      pending_target_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      pending_target_q <= pending_target_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (!bus_io.load_pc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (branch_accept && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign branch_count = branch_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a table-driven model of the stall/flush rules. A second instance with
// 4-bit counters sees identical stimulus to exercise saturation.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_stall_controller_if bif ();
  pipeline_stall_controller_if sif ();

  logic [31:0] stall_cycles, branch_count;
  logic [3:0]  stall_small, branch_small;

  assign sif.imem_read       = bif.imem_read;
  assign sif.imem_resp       = bif.imem_resp;
  assign sif.dmem_access     = bif.dmem_access;
  assign sif.dmem_resp       = bif.dmem_resp;
  assign sif.load_use_hazard = bif.load_use_hazard;
  assign sif.branch_taken_EX = bif.branch_taken_EX;
  assign sif.branch_target   = bif.branch_target;

  pipeline_stall_controller #(.CNT_WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus_io       (bif.slave),
    .stall_cycles (stall_cycles),
    .branch_count (branch_count)
  );

  pipeline_stall_controller #(.CNT_WIDTH(4)) u_dut_small (
    .clk          (clk),
    .rst          (rst),
    .bus_io       (sif.slave),
    .stall_cycles (stall_small),
    .branch_count (branch_small)
  );

  // {load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
  //  flush_if_id, flush_id_ex, bubble_id_ex}
  logic [8:0] ctrl_obs, ctrl_obs_s;
  assign ctrl_obs = {bif.load_pc, bif.pc_redirect, bif.load_if_id, bif.load_id_ex,
                     bif.load_ex_mem, bif.load_mem_wb, bif.flush_if_id, bif.flush_id_ex,
                     bif.bubble_id_ex};
  assign ctrl_obs_s = {sif.load_pc, sif.pc_redirect, sif.load_if_id, sif.load_id_ex,
                       sif.load_ex_mem, sif.load_mem_wb, sif.flush_if_id, sif.flush_id_ex,
                       sif.bubble_id_ex};

  // Scenario codes: 0 reset, 1 D-miss freeze, 2 branch during fetch miss,
  // 3 branch redirect, 4 squash waiting, 5 squash release, 6 load-use,
  // 7 fetch miss, 8 free-running
  localparam logic [8:0] CTRL_TBL [9] = '{
    9'b000000000, 9'b000000000, 9'b001111110, 9'b111111110, 9'b001111100,
    9'b111111100, 9'b000111001, 9'b001111100, 9'b101111000
  };

  // Model state
  bit          squash_m;
  logic [31:0] pend_m;
  longint      stall_m, br_m, stall_s, br_s;
  int          checks, errors;

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int classify();
    bit ms, fs;
    if (rst) return 0;
    ms = bif.dmem_access && !bif.dmem_resp;
    fs = bif.imem_read && !bif.imem_resp;
    if (ms) return 1;
    if (bif.branch_taken_EX) return fs ? 2 : 3;
    if (squash_m) return fs ? 4 : 5;
    if (bif.load_use_hazard) return 6;
    if (fs) return 7;
    return 8;
  endfunction

  task automatic set_in(bit r, bit ir, bit iresp, bit da, bit dr, bit luh, bit bt,
                        logic [31:0] tgt);
    rst                 = r;
    bif.imem_read       = ir;
    bif.imem_resp       = iresp;
    bif.dmem_access     = da;
    bif.dmem_resp       = dr;
    bif.load_use_hazard = luh;
    bif.branch_taken_EX = bt;
    bif.branch_target   = tgt;
  endtask

  // Commit the current cycle to the model, then cross the clock edge
  task automatic advance();
    int code;
    code = classify();
    case (code)
      0: begin
        squash_m = 0; pend_m = 32'h0;
        stall_m = 0; br_m = 0; stall_s = 0; br_s = 0;
      end
      2: begin pend_m = bif.branch_target; squash_m = 1; end
      5: squash_m = 0;
      default: ;
    endcase
    if (code == 2 || code == 3) begin
      br_m = sat(br_m + 1, 32);
      br_s = sat(br_s + 1, 4);
    end
    if (code != 0 && !CTRL_TBL[code][8]) begin
      stall_m = sat(stall_m + 1, 32);
      stall_s = sat(stall_s + 1, 4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h0);
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1, 1, 0, 1, 0, 1, 1, 32'hdead_beef);
    #1;
    checks++;
    if (ctrl_obs !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl_obs, 9'b0);
    end
    advance();
    checks++;
    if (stall_cycles !== 32'd0 || branch_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, branch_count);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b101111000 || bif.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_run: got %b/%h want %b/%h", ctrl_obs, bif.redirect_pc,
               9'b101111000, 32'h0);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b000111001) begin
      errors++; $display("FAIL load_use_ctrl: got %b want %b", ctrl_obs, 9'b000111001);
    end
    advance();
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_dmiss();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 1, 32'h0000_0060);
      #1;
      checks++;
      if (ctrl_obs !== 9'b0) begin
        errors++; $display("FAIL dmiss_freeze[%0d]: got %b want %b", i, ctrl_obs, 9'b0);
      end
      advance();
    end
    set_in(0, 0, 0, 1, 1, 0, 1, 32'h0000_0060);
    #1;
    checks++;
    if (ctrl_obs !== 9'b111111110 || bif.redirect_pc !== 32'h60) begin
      errors++;
      $display("FAIL dmiss_release: got %b/%h want %b/%h", ctrl_obs, bif.redirect_pc,
               9'b111111110, 32'h60);
    end
    advance();
    checks++;
    if (branch_count !== 32'd1 || stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL dmiss_counters: got %0d/%0d want 1/5", branch_count, stall_cycles);
    end
  endtask

  task automatic test_branch_imiss();
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 1, 32'h0000_0400);
    #1;
    checks++;
    if (ctrl_obs !== 9'b001111110) begin
      errors++; $display("FAIL bimiss_branch: got %b want %b", ctrl_obs, 9'b001111110);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 0, 0, 0, 1, 0, 32'h0);
      #1;
      checks++;
      if (ctrl_obs !== 9'b001111100) begin
        errors++; $display("FAIL bimiss_wait[%0d]: got %b want %b", i, ctrl_obs, 9'b001111100);
      end
      advance();
    end
    set_in(0, 1, 1, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b111111100 || bif.redirect_pc !== 32'h400) begin
      errors++;
      $display("FAIL bimiss_redirect: got %b/%h want %b/%h", ctrl_obs, bif.redirect_pc,
               9'b111111100, 32'h400);
    end
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b101111000) begin
      errors++; $display("FAIL bimiss_back_to_run: got %b want %b", ctrl_obs, 9'b101111000);
    end
    advance();
  endtask

  task automatic test_branch_vs_hazard();
    set_in(0, 0, 0, 0, 0, 1, 1, 32'h0000_1234);
    #1;
    checks++;
    if (ctrl_obs !== 9'b111111110 || bif.redirect_pc !== 32'h1234) begin
      errors++;
      $display("FAIL branch_vs_hazard: got %b/%h want %b/%h", ctrl_obs, bif.redirect_pc,
               9'b111111110, 32'h1234);
    end
    advance();
  endtask

  task automatic test_reset_in_squash();
    set_in(0, 1, 0, 0, 0, 0, 1, 32'h0000_0800);
    advance();
    set_in(1, 1, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b0) begin
      errors++; $display("FAIL squash_reset_ctrl: got %b want %b", ctrl_obs, 9'b0);
    end
    advance();
    checks++;
    if (stall_cycles !== 32'd0 || branch_count !== 32'd0) begin
      errors++;
      $display("FAIL squash_reset_cnt: got %0d/%0d want 0/0", stall_cycles, branch_count);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (ctrl_obs !== 9'b101111000 || bif.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL squash_reset_release: got %b/%h want %b/%h", ctrl_obs, bif.redirect_pc,
               9'b101111000, 32'h0);
    end
    advance();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 32'h0);
      advance();
      want = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (stall_small !== 4'(want)) begin
        errors++; $display("FAIL saturation[%0d]: got %0d want %0d", i, stall_small, want);
      end
    end
    checks++;
    if (stall_cycles !== 32'd20) begin
      errors++; $display("FAIL saturation_wide: got %0d want 20", stall_cycles);
    end
  endtask

  task automatic test_random();
    int code;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(39) == 0), $urandom_range(1), $urandom_range(1),
             ($urandom_range(3) == 0), $urandom_range(1), ($urandom_range(3) == 0),
             ($urandom_range(4) == 0), $urandom());
      #1;
      code = classify();
      checks++;
      if (ctrl_obs !== CTRL_TBL[code] || ctrl_obs_s !== CTRL_TBL[code]) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %b/%b want %b", i, ctrl_obs, ctrl_obs_s,
                 CTRL_TBL[code]);
      end
      if (code != 0) begin
        checks++;
        if (bif.redirect_pc !== ((code == 3) ? bif.branch_target : pend_m)) begin
          errors++;
          $display("FAIL rand_redirect[%0d]: got %h want %h", i, bif.redirect_pc,
                   (code == 3) ? bif.branch_target : pend_m);
        end
      end
      advance();
      checks++;
      if (stall_cycles !== 32'(stall_m) || branch_count !== 32'(br_m) ||
          stall_small !== 4'(stall_s) || branch_small !== 4'(br_s)) begin
        errors++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 stall_cycles, branch_count, stall_small, branch_small,
                 stall_m, br_m, stall_s, br_s);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    squash_m = 0; pend_m = 32'h0;
    stall_m = 0; br_m = 0; stall_s = 0; br_s = 0;
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h0);
    advance();
    test_reset();
    test_load_use();
    test_dmiss();
    test_branch_imiss();
    test_branch_vs_hazard();
    test_reset_in_squash();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
